// File: rtl/inst_msg_reader.sv
// Receive side of the scrolling 40-bit instruction window: detects one-character
// shifts, assembles characters into messages and frames them by zero runs or a stall.
module inst_msg_reader #(
  parameter int MAX_CHARS = 16,
  parameter int END_ZEROS = 2,
  parameter int TIMEOUT   = 4
) (
  input  logic                               sec_clock,
  input  logic                               rst,
  input  logic [39:0]                        instruction,
  output logic                               char_valid,
  output logic [4:0]                         char_code,
  output logic                               msg_valid,
  output logic [$clog2(MAX_CHARS+1)-1:0]     msg_len,
  output logic [5*MAX_CHARS-1:0]             msg_data,
  output logic                               msg_overflow
);

  localparam int LEN_W = $clog2(MAX_CHARS+1);
  localparam int ZR_W  = $clog2(END_ZEROS+1);
  localparam int ST_W  = $clog2(TIMEOUT+1);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t            state;
  logic [39:0]       prev;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  last_nz;
  logic [ZR_W-1:0]   zero_run;
  logic [ST_W-1:0]   stall;
  logic              shift;
  logic [4:0]        new_char;

  function automatic int sat_inc(input int v, input int lim);
    return (v >= lim) ? lim : v + 1;
  endfunction

  // A shift moves the whole window up by one character; an unchanged window is not a shift.
  assign shift    = (instruction[39:5] == prev[34:0]) && (instruction != prev);
  assign new_char = instruction[4:0];

  always_ff @(posedge sec_clock) begin
    if (rst) begin
      prev         <= '0;
      state        <= IDLE;
      len          <= '0;
      last_nz      <= '0;
      zero_run     <= '0;
      stall        <= '0;
      char_valid   <= 1'b0;
      char_code    <= '0;
      msg_valid    <= 1'b0;
      msg_len      <= '0;
      msg_data     <= '0;
      msg_overflow <= 1'b0;
    end else begin
      prev       <= instruction;
      char_valid <= shift;
      char_code  <= new_char;
      msg_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (shift && new_char != 5'd0) begin
            msg_data     <= {{(5*MAX_CHARS-5){1'b0}}, new_char};
            len          <= LEN_W'(1);
            last_nz      <= LEN_W'(1);
            zero_run     <= '0;
            stall        <= '0;
            msg_overflow <= 1'b0;
            state        <= RECV;
          end
        end
        RECV: begin
          if (shift && new_char != 5'd0) begin
            if (int'(len) < MAX_CHARS) begin
              msg_data[5*int'(len) +: 5] <= new_char;
              len                        <= len + 1'b1;
              last_nz                    <= len + 1'b1;
            end else begin
              msg_overflow <= 1'b1;
            end
            zero_run <= '0;
            stall    <= '0;
          end else if (shift) begin
            zero_run <= ZR_W'(sat_inc(int'(zero_run), END_ZEROS));
            stall    <= '0;
            if (int'(len) < MAX_CHARS) begin
              msg_data[5*int'(len) +: 5] <= 5'd0;
              len                        <= len + 1'b1;
            end
            if (sat_inc(int'(zero_run), END_ZEROS) >= END_ZEROS) begin
              msg_valid <= 1'b1;
              msg_len   <= last_nz;
              state     <= DONE;
            end
          end else begin
            stall <= ST_W'(sat_inc(int'(stall), TIMEOUT));
            if (sat_inc(int'(stall), TIMEOUT) >= TIMEOUT) begin
              msg_valid <= 1'b1;
              msg_len   <= last_nz;
              state     <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_msg_reader.sv
// Bench for inst_msg_reader: directed scenarios plus random traffic, compared each
// cycle against a queue-based message model.
module tb_inst_msg_reader;

  localparam int MAX_CHARS = 16;
  localparam int END_ZEROS = 2;
  localparam int TIMEOUT   = 4;

  logic        sec_clock;
  logic        rst;
  logic [39:0] instruction;
  logic        char_valid;
  logic [4:0]  char_code;
  logic        msg_valid;
  logic [4:0]  msg_len;
  logic [79:0] msg_data;
  logic        msg_overflow;

  inst_msg_reader #(.MAX_CHARS(MAX_CHARS), .END_ZEROS(END_ZEROS), .TIMEOUT(TIMEOUT)) dut (
    .sec_clock   (sec_clock),
    .rst         (rst),
    .instruction (instruction),
    .char_valid  (char_valid),
    .char_code   (char_code),
    .msg_valid   (msg_valid),
    .msg_len     (msg_len),
    .msg_data    (msg_data),
    .msg_overflow(msg_overflow)
  );

  initial sec_clock = 1'b0;
  always #5 sec_clock = ~sec_clock;

  int n_chk  = 0;
  int n_pass = 0;

  // model state: message as a queue of codes, mode 0=idle 1=receiving 2=done
  int          q[$];
  int          m_mode = 0;
  int          zr = 0;
  int          st = 0;
  bit          ovf = 0;
  logic [39:0] mprev = '0;
  logic [39:0] w = '0;

  bit          e_cv, e_mv, e_rst, e_ovf;
  logic [4:0]  e_cc;
  int          e_len;
  logic [79:0] e_data;

  int          msg_cnt = 0;
  int          obs_len = 0;
  logic [79:0] obs_data = '0;
  bit          obs_ovf = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int q_last_nz();
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i] != 0) return i + 1;
    return 0;
  endfunction

  function automatic logic [79:0] q_pack();
    logic [79:0] d = '0;
    for (int i = 0; i < q.size(); i++) d[5*i +: 5] = 5'(q[i]);
    return d;
  endfunction

  task automatic step(input logic [39:0] wv, input logic r);
    bit         sh;
    bit         fin;
    logic [4:0] nc;
    instruction = wv;
    rst         = r;
    w           = wv;
    @(posedge sec_clock);
    e_mv  = 0;
    e_rst = r;
    e_cv  = 0;
    e_cc  = '0;
    if (r) begin
      mprev = '0; m_mode = 0; q.delete(); zr = 0; st = 0; ovf = 0;
      e_len = 0; e_ovf = 0; e_data = '0;
    end else begin
      sh   = (wv[39:5] == mprev[34:0]) && (wv != mprev);
      nc   = wv[4:0];
      e_cv = sh;
      e_cc = nc;
      fin  = 0;
      if (m_mode == 0) begin
        if (sh && nc != 0) begin
          q.delete(); q.push_back(int'(nc)); zr = 0; st = 0; ovf = 0; m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (sh && nc != 0) begin
          if (q.size() < MAX_CHARS) q.push_back(int'(nc)); else ovf = 1;
          zr = 0; st = 0;
        end else if (sh) begin
          zr++; st = 0;
          if (q.size() < MAX_CHARS) q.push_back(0);
          fin = (zr >= END_ZEROS);
        end else begin
          st++;
          fin = (st >= TIMEOUT);
        end
        if (fin) begin
          e_mv = 1; e_len = q_last_nz(); e_ovf = ovf; e_data = q_pack(); m_mode = 2;
        end
      end else begin
        m_mode = 0;
      end
      mprev = wv;
    end
    @(negedge sec_clock);
    check("char_valid", 96'(char_valid), 96'(e_cv));
    if (e_cv) check("char_code", 96'(char_code), 96'(e_cc));
    check("msg_valid", 96'(msg_valid), 96'(e_mv));
    if (e_mv || e_rst) begin
      check("msg_len", 96'(msg_len), 96'(e_len));
      check("msg_data", 96'(msg_data), 96'(e_data));
      check("msg_overflow", 96'(msg_overflow), 96'(e_ovf));
    end
    if (msg_valid) begin
      msg_cnt++; obs_len = int'(msg_len); obs_data = msg_data; obs_ovf = msg_overflow;
    end
  endtask

  task automatic shift_in(input int c);
    step({w[34:0], 5'(c)}, 1'b0);
  endtask

  task automatic hold(input int n);
    repeat (n) step(w, 1'b0);
  endtask

  task automatic do_reset();
    step('0, 1'b1);
  endtask

  int          bal[12] = '{19, 8, 15, 23, 0, 2, 1, 12, 1, 14, 3, 5};
  int          base;
  int          sel;
  logic [79:0] exp_ok;

  initial begin
    rst = 1'b1;
    instruction = '0;
    @(negedge sec_clock);
    do_reset();
    do_reset();

    // balance sequence
    base = msg_cnt;
    foreach (bal[i]) shift_in(bal[i]);
    shift_in(0);
    shift_in(0);
    hold(2);
    check("bal_count", 96'(msg_cnt - base), 96'(1));
    check("bal_len", 96'(obs_len), 96'(12));
    check("bal_first", 96'(obs_data[4:0]), 96'(19));
    check("bal_last", 96'(obs_data[59:55]), 96'(5));
    check("bal_space", 96'(obs_data[24:20]), 96'(0));
    check("bal_ovf", 96'(obs_ovf), 96'(0));

    // stall timeout
    do_reset();
    base = msg_cnt;
    shift_in(1);
    shift_in(2);
    hold(6);
    check("stall_count", 96'(msg_cnt - base), 96'(1));
    check("stall_len", 96'(obs_len), 96'(2));

    // overflow
    do_reset();
    base = msg_cnt;
    for (int i = 1; i <= 20; i++) shift_in(i);
    shift_in(0);
    shift_in(0);
    hold(2);
    check("ovf_count", 96'(msg_cnt - base), 96'(1));
    check("ovf_len", 96'(obs_len), 96'(16));
    check("ovf_flag", 96'(obs_ovf), 96'(1));
    for (int i = 0; i < 16; i++) check("ovf_data", 96'(obs_data[5*i +: 5]), 96'(i + 1));

    // leading zeros, then reset mid-message
    do_reset();
    base = msg_cnt;
    shift_in(0); shift_in(0); shift_in(0);
    shift_in(7);
    step(w, 1'b1);
    w = '0;
    hold(6);
    check("rst_no_msg", 96'(msg_cnt - base), 96'(0));
    shift_in(4); shift_in(5); shift_in(0); shift_in(0);
    hold(2);
    check("rst_fresh_count", 96'(msg_cnt - base), 96'(1));
    check("rst_fresh_len", 96'(obs_len), 96'(2));

    // back-to-back messages (a quiet cycle lets DONE pass)
    do_reset();
    base = msg_cnt;
    shift_in(8); shift_in(9); shift_in(0); shift_in(0);
    hold(1);
    check("b2b_first_len", 96'(obs_len), 96'(2));
    shift_in(15); shift_in(11); shift_in(0); shift_in(0);
    hold(2);
    exp_ok = '0;
    exp_ok[4:0] = 5'd15;
    exp_ok[9:5] = 5'd11;
    check("b2b_count", 96'(msg_cnt - base), 96'(2));
    check("b2b_len", 96'(obs_len), 96'(2));
    check("b2b_data", 96'(obs_data), 96'(exp_ok));
    check("b2b_ovf", 96'(obs_ovf), 96'(0));

    // non-shift window change counts as a stall
    do_reset();
    base = msg_cnt;
    shift_in(3);
    step(40'hF0F0F0F0F0, 1'b0);
    check("ns_no_char", 96'(char_valid), 96'(0));
    hold(5);
    check("ns_count", 96'(msg_cnt - base), 96'(1));
    check("ns_len", 96'(obs_len), 96'(1));

    // random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 2) step(w, 1'b1);
      else if (sel < 60) shift_in(($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 31)));
      else if (sel < 88) hold(1);
      else step({8'($urandom), 32'($urandom)}, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/inst_msg_reader.md
Name: inst_msg_reader

Overview:
- Receive-side counterpart of the 40-bit scrolling instruction window. The window holds 8 five-bit character codes; code 0 is space/blank, and the newest character is in bits [4:0].
- Each sec_clock cycle the block compares the window against its previous value to detect a one-character shift, then extracts the new character.
- It assembles characters into a message buffer, frames messages by zero-code runs or a stall timeout, and presents each completed message with a valid pulse.
- It sits between the message generators and the command/display logic.

Parameters:
- MAX_CHARS, 16, message buffer capacity in characters.
- END_ZEROS, 2, consecutive zero codes that terminate a message (must be ≥1).
- TIMEOUT, 4, consecutive no-shift cycles in RECV that terminate a message (must be ≥1).

Ports:
- sec_clock  in  1  clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- instruction  in  40  scrolling window; newest character in [4:0].
- char_valid  out  1  one-cycle pulse: a new character was shifted in.
- char_code  out  5  code of that character; valid only with char_valid.
- msg_valid  out  1  one-cycle pulse: message complete.
- msg_len  out  $clog2(MAX_CHARS+1)  number of characters up to and including the last nonzero one.
- msg_data  out  5*MAX_CHARS  character i is at [5i+4:5i]; i=0 is the first received character.
- msg_overflow  out  1  message exceeded MAX_CHARS; held with msg_data.

Behaviour:
- Reset (rst=1 at posedge):
  - prev window = 0; state = IDLE.
  - All counters = 0.
  - char_valid, msg_valid, msg_overflow, msg_len, msg_data = 0.
  - Applies mid-message: the partial message is discarded and no msg_valid is issued.
- Shift detect (combinational on sampled inputs):
  - shift = (instruction[39:5] == prev[34:0]) && (instruction != prev).
  - new_char = instruction[4:0].
  - prev <= instruction every cycle.
  - A shift that leaves the window unchanged (e.g. zero into an all-zero window) is not detected. This is accepted.
- char_valid/char_code are registered: asserted at the edge that samples the shift, in every state.
- States:
  - IDLE:
    - Zero-code shifts and no-shift cycles are ignored.
    - On a nonzero shift: clear buffer; store char at index 0; len=1, last_nz=1; zero_run=0; stall=0; msg_overflow=0; go to RECV.
  - RECV, nonzero shift:
    - If len<MAX_CHARS: store at index len; len++; last_nz=len.
    - Else: drop the char; msg_overflow<=1.
    - In both cases zero_run=0 and stall=0.
  - RECV, zero shift:
    - zero_run++; stall=0.
    - If len<MAX_CHARS, store 0 at index len and len++; otherwise no store.
    - If zero_run reaches END_ZEROS, go to DONE.
  - RECV, no shift:
    - stall++.
    - If stall reaches TIMEOUT, go to DONE.
  - DONE (1 cycle):
    - msg_valid=1; msg_len=last_nz.
    - msg_data holds the buffer. Positions ≥ msg_len read 0, because the buffer is cleared at start and trailing stored codes are zeros.
    - A shift arriving in this cycle still produces char_valid but is not captured.
    - Then go to IDLE.
- msg_data, msg_len and msg_overflow hold until the next message start in IDLE, or until reset.
- msg_valid is high only in the cycle after the terminating edge.
- Internal spaces (single zero codes) are kept in the message.
- Counters saturate: stall stops at TIMEOUT, zero_run stops at END_ZEROS.
- No combinational input-to-output paths.

Test Plan:
- Balance sequence: after reset, drive the generator pattern. Each cycle shift in S,H,O,W,0,B,A,L,A,N,C,E (19,8,15,23,0,2,1,12,1,14,3,5), then zero codes. Required:
  - 12 char_valid pulses with codes in that order, plus pulses for the zero codes.
  - msg_valid one cycle after the 2nd trailing zero shift.
  - msg_len=12; msg_data[4:0]=19, [59:55]=5, [24:20]=0; msg_overflow=0.
- Stall timeout: shift A,B (1,2), then hold the window constant. Required: msg_valid in the cycle after the 4th no-shift cycle; msg_len=2.
- Overflow: shift 20 nonzero codes (1..20), then two zeros. Required: msg_len=16, msg_overflow=1, msg_data holds codes 1..16.
- Leading zeros and reset: shift 3 zero codes in IDLE → no message starts. Then shift 7 and assert rst mid-message → no msg_valid; all outputs 0 next cycle. A fresh message after reset is received correctly.
- Back-to-back messages: "HI", 0, 0, then "OK", 0, 0. Required:
  - Two msg_valid pulses, with msg_len 2 each.
  - Second msg_data = O,K with upper slots 0; msg_overflow cleared.
- Non-shift change: load an unrelated window value (not a 5-bit shift). Required: no char_valid; in RECV it counts as a stall cycle.
